hwpe_stream_tcdm_load_arbiter: RTL
==================================

# hwpe_stream_tcdm_load_arbiter

Round-robin arbiter that shares one HWPE-MemDecoupled load port among `NB_IN` load requesters, e.g. several streamers feeding one TCDM load FIFO. It tracks every granted request in an in-order ID queue so that each `r_valid`/`r_data` returns to the requester that issued it. It sits between the streamers' TCDM masters and the downstream load FIFO or TCDM port.

## Interface
- `NB_IN`, 4: number of requesters, 2..16.
- `MAX_OUTSTANDING`, 8: depth of the ID queue, a power of 2, at least 2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous clear, same effect as reset.
- `flags_o`  out  `flags_tcdm_arb_t`  status flags: `empty`, `full`, `outstanding[$clog2(MAX_OUTSTANDING):0]`, `error`.
- `tcdm_slave[NB_IN]`  `hwpe_stream_intf_tcdm.slave`  requester ports; `add`, `req`, `gnt`, `r_data` and `r_valid` are used.
- `tcdm_master`  `hwpe_stream_intf_tcdm.master`  shared port. `wen`=1, `be`='1, `data`='0.

## Operation
- **Selection.** Start at priority pointer `ptr`. The selected requester `sel` is the first `i` at or after `ptr`, modulo `NB_IN`, with `tcdm_slave[i].req`=1.
- **Lock.** If `tcdm_master.req`=1 and `gnt`=0 in a cycle, set `lock`=1 and store `sel` in `lock_idx`. While `lock`=1, `sel`=`lock_idx`, so `add` stays stable downstream. `lock` clears on the handshake.
- **Master request.**
  - `tcdm_master.req` = any slave `req` AND `!full`.
  - `tcdm_master.add` = `tcdm_slave[sel].add`.
- **Grant.** `tcdm_slave[i].gnt` = `tcdm_master.gnt` AND (`i`==`sel`) AND `!full`. Every other requester sees `gnt`=0.
- **Handshake** (master `req` & `gnt`):
  - push `sel` into the ID queue;
  - set `ptr` = (`sel`+1) mod `NB_IN`.
  - `ptr` does not change in any other cycle.
- **Response.** `tcdm_master.r_valid`=1 pops the queue head `h`.
  - `tcdm_slave[h].r_valid`=1 and `r_data`=`tcdm_master.r_data`, combinationally.
  - Every other slave has `r_valid`=0 and `r_data` = master `r_data` (don't-care).
- **Outstanding counter.**
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
  - `full` = (`outstanding`==`MAX_OUTSTANDING`). `empty` = (`outstanding`==0).
- **Full.** Master `req` is forced to 0. A pop in that same cycle does not re-enable `req` until the next cycle, because `full` comes from the registered count.
- **Error.** `r_valid` while `empty` sets `error` (sticky until reset/clear). The pop is ignored, no slave `r_valid` is raised, and the counter does not underflow.
- **Reset/clear.**
  - `ptr`=0, `lock`=0, `outstanding`=0, queue pointers=0, `error`=0.
  - Outstanding IDs are discarded. Drain before clearing; responses that arrive after the clear set `error`.

## Timing
- Request path is fully combinational, with zero added latency: slave `req` → master `req`, and master `gnt` → slave `gnt`.
- Response path is combinational: master `r_valid` → slave `r_valid`. The responder's latency is preserved.
- Queue, pointer, lock and counter update on the `clk_i` edge after the event.
- After reset, with all slave `req`=0:
  - master `req`=0, every slave `gnt`=0, every slave `r_valid`=0;
  - `flags_o` = {`empty`=1, `full`=0, `outstanding`=0, `error`=0}.
- Responses must return in request order. The block does not reorder.

## Structure
- `hwpe_stream_package`: add the `flags_tcdm_arb_t` typedef.
- Sub-module `hwpe_stream_tcdm_arb_idq`: the ID queue.
  - Circular buffer `MAX_OUTSTANDING` × `$clog2(NB_IN)`.
  - Read/write pointers plus a count, with a combinational head output.
- Round-robin selection, lock and gating live in the top module.

## Test plan
1. **Round-robin.**
   - Stimulus: `NB_IN`=4, all four requesters hold `req`=1, master `gnt`=1 every cycle, responses return 1 cycle after grant.
   - Required: grants go 0,1,2,3,0,…; requester `i` receives its `r_data` exactly 1 cycle after its grant.
2. **Lock.**
   - Stimulus: requester 2 selected, master `gnt`=0 for 3 cycles while requester 1 raises `req`.
   - Required: `add` is held at requester 2's address; requester 2 gets the grant on cycle 4; requester 3 is next in order, requester 1 waits for `ptr` to wrap.
3. **Full.**
   - Stimulus: `MAX_OUTSTANDING`=8, responder stalls. 8 grants occur.
   - Required: `full`=1 and master `req`=0. One `r_valid` gives `outstanding`=7, and `req` rises the next cycle.
4. **Simultaneous push and pop.**
   - Stimulus: at `outstanding`=3, a handshake and an `r_valid` occur in the same cycle.
   - Required: `outstanding` stays 3; the head response goes to the oldest ID.
5. **Spurious response.**
   - Stimulus: `r_valid` while empty.
   - Required: `error`=1, no slave `r_valid`, `outstanding` stays 0, `error` holds until `clear_i`.
6. **Reset mid-operation.**
   - Stimulus: assert `rst_ni`=0 with 5 requests outstanding and `lock`=1.
   - Required: all flags return to reset values; after release, requester 0 has priority.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE-Stream TCDM helpers.
// The TCDM load arbiter status word is defined here so that controllers can
// read it without depending on the arbiter's parameters.
package hwpe_stream_package;

  // Width of the outstanding-request field. It is sized for queue depths up to 128.
  // Smaller queues zero-extend their count into it.
  localparam int unsigned TCDM_ARB_CNT_W = 8;

  typedef struct packed {
    logic                      empty;
    logic                      full;
    logic [TCDM_ARB_CNT_W-1:0] outstanding;
    logic                      error;
  } flags_tcdm_arb_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// HWPE-MemDecoupled TCDM port: request channel (req/gnt/add/wen/be/data)
// and response channel (r_valid/r_data).
interface hwpe_stream_intf_tcdm;

  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/hwpe_stream_tcdm_arb_idq.sv
// In-order ID queue for the TCDM load arbiter. It records which requester
// owns each granted load and presents the oldest one combinationally.
// Pushes while full and pops while empty are dropped.
module hwpe_stream_tcdm_arb_idq
  import hwpe_stream_package::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_id_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [PW:0]   cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (cnt_r == {(PW+1){1'b0}});
  assign full_o    = (cnt_r == (PW+1)'(DEPTH));
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_r[rptr_r];
  assign count_o   = cnt_r;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
      cnt_r  <= {(PW+1){1'b0}};
    end else if (clear_i) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
      cnt_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + (PW+1)'(1'b1);
        2'b01:   cnt_r <= cnt_r - (PW+1)'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // ID storage. It is cleared with the pointers so that the head is never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wptr_r] <= push_id_i;
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_load_arbiter.sv
// Round-robin arbiter that shares one TCDM load port among NB_IN requesters.
// Request and response paths are combinational. The ID queue returns each
// response to the requester that issued the matching request.
module hwpe_stream_tcdm_load_arbiter
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_IN           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  output flags_tcdm_arb_t      flags_o,
  hwpe_stream_intf_tcdm.slave  tcdm_slave [NB_IN-1:0],
  hwpe_stream_intf_tcdm.master tcdm_master
);

  localparam int unsigned IDW = $clog2(NB_IN);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;

  logic [NB_IN-1:0] req_s;
  logic [31:0]      add_s [NB_IN];
  logic [NB_IN-1:0] gnt_s;
  logic [NB_IN-1:0] rvalid_s;
  logic [NB_IN-1:0] slave_unused_s;

  logic [IDW-1:0]   ptr_r;
  logic             lock_r;
  logic [IDW-1:0]   lock_idx_r;
  logic             error_r;

  logic [IDW-1:0]   rr_sel_s;
  logic [IDW-1:0]   sel_s;
  logic [IDW-1:0]   next_ptr_s;
  logic [IDW-1:0]   head_s;
  logic [CW-1:0]    cnt_s;
  logic             empty_s;
  logic             full_s;
  logic             any_req_s;
  logic             mreq_s;
  logic             hs_s;
  logic             pop_s;
  logic             err_set_s;

  // (base + off) mod NB_IN. off < NB_IN, so one subtraction is enough.
  function automatic logic [IDW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned v;
    v = base + off;
    if (v >= NB_IN) begin
      v = v - NB_IN;
    end else begin
      v = v;
    end
    return IDW'(v);
  endfunction

  for (genvar g = 0; g < int'(NB_IN); g++) begin : gen_slave
    assign req_s[g]               = tcdm_slave[g].req;
    assign add_s[g]               = tcdm_slave[g].add;
    assign tcdm_slave[g].gnt      = gnt_s[g];
    assign tcdm_slave[g].r_valid  = rvalid_s[g];
    assign tcdm_slave[g].r_data   = tcdm_master.r_data;
    // Store-side fields are irrelevant on a load-only port.
    assign slave_unused_s[g]      = ^{tcdm_slave[g].wen, tcdm_slave[g].be, tcdm_slave[g].data};
  end

  // Scan from the farthest candidate back to ptr, so that the nearest requester at or after ptr wins.
  always_comb begin
    rr_sel_s = ptr_r;
    for (int k = int'(NB_IN) - 1; k >= 0; k--) begin
      if (req_s[wrap_idx(32'(ptr_r), 32'(k))]) begin
        rr_sel_s = wrap_idx(32'(ptr_r), 32'(k));
      end else begin
        rr_sel_s = rr_sel_s;
      end
    end
  end

  assign sel_s      = lock_r ? lock_idx_r : rr_sel_s;
  assign next_ptr_s = wrap_idx(32'(sel_s), 32'd1);
  assign any_req_s  = |req_s;
  assign mreq_s     = any_req_s & ~full_s;
  assign hs_s       = mreq_s & tcdm_master.gnt;
  assign pop_s      = tcdm_master.r_valid & ~empty_s;
  assign err_set_s  = tcdm_master.r_valid & empty_s;

  // Forward only the grant of a real handshake, and only to the selected requester.
  always_comb begin
    gnt_s = {NB_IN{1'b0}};
    for (int i = 0; i < int'(NB_IN); i++) begin
      gnt_s[i] = hs_s & (sel_s == IDW'(i));
    end
  end

  // Route the response to the owner of the oldest outstanding ID.
  always_comb begin
    rvalid_s = {NB_IN{1'b0}};
    for (int i = 0; i < int'(NB_IN); i++) begin
      rvalid_s[i] = pop_s & (head_s == IDW'(i));
    end
  end

  assign tcdm_master.req  = mreq_s;
  assign tcdm_master.add  = add_s[sel_s];
  assign tcdm_master.wen  = 1'b1;
  assign tcdm_master.be   = 4'hF;
  assign tcdm_master.data = 32'h0000_0000;

  // Advance priority past the winner on a handshake, and freeze the selection while a request is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_r      <= {IDW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IDW{1'b0}};
    end else if (clear_i) begin
      ptr_r      <= {IDW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IDW{1'b0}};
    end else if (hs_s) begin
      ptr_r  <= next_ptr_s;
      lock_r <= 1'b0;
    end else if (mreq_s) begin
      lock_r     <= 1'b1;
      lock_idx_r <= sel_s;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_r <= 1'b0;
    end else if (clear_i) begin
      error_r <= 1'b0;
    end else if (err_set_s) begin
      error_r <= 1'b1;
    end
  end

  hwpe_stream_tcdm_arb_idq #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (IDW)
  ) i_idq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .push_i    (hs_s),
    .push_id_i (sel_s),
    .pop_i     (pop_s),
    .head_o    (head_s),
    .count_o   (cnt_s),
    .empty_o   (empty_s),
    .full_o    (full_s)
  );

  // Status flags are decoded from registered state only.
  always_comb begin
    flags_o             = '0;
    flags_o.empty       = empty_s;
    flags_o.full        = full_s;
    flags_o.outstanding = TCDM_ARB_CNT_W'(cnt_s);
    flags_o.error       = error_r;
  end

endmodule
